bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, BRAM word width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 801, BRAM depth in words.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse launching a burst.
REQ-007 SHALL have port base_addr  in  32  byte address of first word (bits[1:0] ignored).
REQ-008 SHALL have port len  in  10  number of words to read.
REQ-009 SHALL have ports busy, done, err  out  1 each  burst active / completion pulse / rejection pulse.
REQ-010 SHALL have ports R_req out 1, addr out 32, R_data in DATA_W, W_req out 4, W_data out DATA_W  BRAM side.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_data out DATA_W  stream output.

Function
REQ-012 SHALL drive W_req=4'b0000 and W_data=0 constantly; never writes BRAM.
REQ-013 SHALL use states IDLE, FETCH, DRAIN.
REQ-014 IDLE: start with len!=0 (and check passing) latches base_addr&~3 and len, goes FETCH, busy=1 from next cycle.
REQ-015 IDLE: start with len==0 pulses done one cycle later, issues no read, stays IDLE.
REQ-016 start while busy SHALL be ignored; latched parameters unchanged.
REQ-017 FETCH: issue read (R_req=1, addr=current) only when fifo_count + reads_in_flight < FIFO_DEPTH; otherwise R_req=0.
REQ-018 BRAM read latency is one cycle: R_data sampled on the cycle after R_req=1 and pushed into FIFO that cycle.
REQ-019 Address SHALL increment by 4 per issued read, wrapping modulo 2^32.
REQ-020 After len reads issued, go DRAIN; R_req=0 thereafter.
REQ-021 DRAIN: when FIFO empty and no read in flight, pulse done one cycle, busy=0, go IDLE.
REQ-022 m_valid=1 iff FIFO non-empty; m_data = FIFO head; word pops when m_valid&&m_ready.
REQ-023 Push and pop in same cycle SHALL both occur; count unchanged; FIFO SHALL never overflow or underflow.
REQ-024 Words SHALL leave in ascending address order, no drops, no duplicates.
REQ-025 Peak throughput SHALL be one word per cycle with m_ready held high.

Reset
REQ-026 rst=1 SHALL force IDLE, FIFO empty, in-flight cleared; busy, done, err, R_req, m_valid = 0; addr = 0.
REQ-027 rst mid-burst SHALL abandon burst without done; BRAM data returning next cycle SHALL be discarded.

Configuration
REQ-028 Macro BRAM_READER_ADDR_CHECK_EN defined: start with (base_addr>>2)+len > DEPTH_WORDS SHALL pulse err one cycle later, issue no reads, no done, stay IDLE.
REQ-029 Macro undefined: no check, err tied 0, out-of-range burst proceeds per REQ-014.

Structure
REQ-030 Shared package SHALL hold state enum (IDLE/FETCH/DRAIN), BRAM_WORD_BYTES=4, default DEPTH_WORDS=801.
REQ-031 FIFO SHALL be a sub-module, stream_fifo (parameterised width/depth, push/pop/count/empty/full).

Verification
REQ-032 base=0x10, len=3, m_ready=1: addr 0x10,0x14,0x18 on consecutive cycles; m_data = bram[4],[5],[6]; done 1 cycle after last pop.
REQ-033 len=8, m_ready=0 for 10 cycles: exactly FIFO_DEPTH(4) reads issued, R_req then 0; release -> all 8 words in order.
REQ-034 len=0 start: done pulse next cycle, R_req never 1, busy stays 0.
REQ-035 rst asserted 2 cycles into len=5 burst: next cycle busy=0, m_valid=0, no done; new burst base=0 len=1 returns bram[0].
REQ-036 ADDR_CHECK_EN, base=0xC78 (word 798), len=5: err pulse, zero reads; len=3: accepted, 3 words, done.
REQ-037 start pulsed mid-burst with different base: ignored; original sequence unchanged.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared state encoding and BRAM constants for the stream reader
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam int BRAM_WORD_BYTES = 4;
  localparam int DEFAULT_DEPTH_WORDS = 801;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: small circular output buffer with occupancy count; push/pop guarded against over/underflow
module stream_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
  // storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: bursts words out of a 1-cycle-latency BRAM into a ready/valid stream; bounds check enabled by BRAM_READER_ADDR_CHECK_EN
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [9:0]        len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              R_req,
  output logic [31:0]       addr,
  input  logic [DATA_W-1:0] R_data,
  output logic [3:0]        W_req,
  output logic [DATA_W-1:0] W_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);
  localparam int CW = $clog2(FIFO_DEPTH);
`ifdef BRAM_READER_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0] remain_q, remain_d;
  logic inflight_q, done_q, done_d, err_q, err_d;
  logic [CW:0] count;
  logic empty, full, push, pop, oob, finish;
  stream_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .din_i(R_data), .pop_i(pop),
    .dout_o(m_data), .count_o(count), .empty_o(empty), .full_o(full)
  );
  assign oob = CHECK_EN && ((({1'b0, base_addr} >> 2) + 33'(len)) > 33'(DEPTH_WORDS));
  assign push = inflight_q && !full;
  assign pop = !empty && m_ready;
  assign m_valid = !empty;
  assign R_req = state_q == FETCH && remain_q != '0 && (int'(count) + int'(inflight_q) < FIFO_DEPTH);
  assign finish = state_q == DRAIN && !inflight_q && (empty || (count == (CW+1)'(1) && pop));
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign addr = addr_q;
  assign W_req = 4'b0000;
  assign W_data = '0;
  // burst sequencing: accept/reject start, issue reads under credit, finish once drained
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    remain_d = remain_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE && start) begin
      if (len == '0) done_d = 1'b1;
      else if (oob) err_d = 1'b1;
      else begin
        state_d = FETCH;
        addr_d = base_addr & ~32'd3;
        remain_d = len;
      end
    end
    if (R_req) begin
      addr_d = addr_q + 32'(BRAM_WORD_BYTES);
      remain_d = remain_q - 10'd1;
      state_d = remain_q == 10'd1 ? DRAIN : state_q;
    end
    if (finish) begin
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  // state registers; in-flight flag tracks last cycle's read so its data lands next cycle
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      remain_q <= remain_d;
      inflight_q <= R_req;
      done_q <= done_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed scenarios against a behavioural 1-cycle BRAM
module tb_bram_stream_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic [31:0] base_addr = '0;
  logic [9:0] len = '0;
  logic busy, done, err, R_req, m_valid;
  logic [31:0] addr, R_data, W_data, m_data;
  logic [3:0] W_req;
  logic [31:0] bram [1024];
  logic [31:0] rd_addrs[$], got[$];
  int rd_cyc[$], pop_cyc[$];
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, cyc = 0;
  int pass = 0, total = 0;

  bram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .err(err), .R_req(R_req), .addr(addr),
    .R_data(R_data), .W_req(W_req), .W_data(W_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bw(input int i);
    return 32'hA500_0000 + i;
  endfunction

  initial for (int i = 0; i < 1024; i++) bram[i] = bw(i);

  always @(posedge clk) if (R_req) R_data <= bram[addr[11:2]];

  always @(posedge clk) begin
    if (R_req) begin rd_addrs.push_back(addr); rd_cyc.push_back(cyc); end
    if (m_valid && m_ready) begin got.push_back(m_data); pop_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    cyc++;
  end

  task automatic clear();
    rd_addrs.delete(); got.delete(); rd_cyc.delete(); pop_cyc.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic pulse(input logic [31:0] b, input logic [9:0] l);
    start = 1'b1; base_addr = b; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (done_cnt == 0) $display("FAIL %s_done: done not seen within %0d cycles", nm, n); else pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, err, R_req, m_valid} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, done, err, R_req, m_valid}); else pass++;
    total++;
    if (addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", addr); else pass++;
    total++;
    if (W_req !== 4'b0 || W_data !== 32'h0) $display("FAIL reset_write: W_req %b W_data %h want 0", W_req, W_data); else pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    clear(); m_ready = 1'b1;
    pulse(32'h10, 10'd3);
    total++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass++;
    wait_done("basic");
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_idle: busy %b done %b want 0 0", busy, done); else pass++;
    total++;
    if (rd_addrs.size() != 3) $display("FAIL basic_nreads: got %0d want 3", rd_addrs.size()); else pass++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_addrs[i] !== 32'h10 + 4 * i) $display("FAIL basic_addr%0d: got %h want %h", i, rd_addrs[i], 32'h10 + 4 * i); else pass++;
      total++;
      if (got[i] !== bw(4 + i)) $display("FAIL basic_data%0d: got %h want %h", i, got[i], bw(4 + i)); else pass++;
    end
    total++;
    if (rd_cyc[2] - rd_cyc[0] != 2) $display("FAIL basic_read_spacing: got %0d want 2", rd_cyc[2] - rd_cyc[0]); else pass++;
    total++;
    if (done_cyc != pop_cyc[2] + 1) $display("FAIL basic_done_timing: done cycle %0d want %0d", done_cyc, pop_cyc[2] + 1); else pass++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    clear(); m_ready = 1'b0;
    pulse(32'h40, 10'd8);
    repeat (10) @(negedge clk);
    total++;
    if (rd_addrs.size() != 4) $display("FAIL bp_credit_reads: got %0d want 4", rd_addrs.size()); else pass++;
    total++;
    if (R_req !== 1'b0 || m_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_stall: R_req %b m_valid %b busy %b want 0 1 1", R_req, m_valid, busy); else pass++;
    m_ready = 1'b1;
    wait_done("bp");
    total++;
    if (got.size() != 8) $display("FAIL bp_nwords: got %0d want 8", got.size()); else pass++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] !== bw(16 + i)) $display("FAIL bp_data%0d: got %h want %h", i, got[i], bw(16 + i)); else pass++;
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    clear(); m_ready = 1'b1;
    pulse(32'h80, 10'd0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: done %b busy %b want 1 0", done, busy); else pass++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_pulse: done %b busy %b want 0 0", done, busy); else pass++;
    repeat (3) @(negedge clk);
    total++;
    if (rd_addrs.size() != 0 || done_cnt != 1) $display("FAIL zero_noread: reads %0d dones %0d want 0 1", rd_addrs.size(), done_cnt); else pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear(); m_ready = 1'b1;
    pulse(32'h20, 10'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || R_req !== 1'b0) $display("FAIL rstmid_state: busy %b m_valid %b R_req %b want 0 0 0", busy, m_valid, R_req); else pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done_cnt != 0) $display("FAIL rstmid_discard: m_valid %b busy %b dones %0d want 0 0 0", m_valid, busy, done_cnt); else pass++;
    clear();
    pulse(32'h0, 10'd1);
    wait_done("rstmid");
    total++;
    if (got.size() != 1 || got[0] !== bw(0)) $display("FAIL rstmid_new: n %0d data %h want 1 %h", got.size(), got[0], bw(0)); else pass++;
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    clear(); m_ready = 1'b1;
    pulse(32'h100, 10'd4);
    pulse(32'h200, 10'd2);
    wait_done("ignore");
    repeat (3) @(negedge clk);
    total++;
    if (rd_addrs.size() != 4 || done_cnt != 1) $display("FAIL ignore_count: reads %0d dones %0d want 4 1", rd_addrs.size(), done_cnt); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_addrs[i] !== 32'h100 + 4 * i || got[i] !== bw(64 + i)) $display("FAIL ignore_word%0d: addr %h data %h want %h %h", i, rd_addrs[i], got[i], 32'h100 + 4 * i, bw(64 + i)); else pass++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clear(); m_ready = 1'b1;
    pulse(32'h203, 10'd6);
    wait_done("b2b");
    total++;
    if (pop_cyc.size() != 6 || pop_cyc[5] - pop_cyc[0] != 5) $display("FAIL b2b_rate: pops %0d span %0d want 6 5", pop_cyc.size(), pop_cyc[5] - pop_cyc[0]); else pass++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== bw(128 + i)) $display("FAIL b2b_data%0d: got %h want %h", i, got[i], bw(128 + i)); else pass++;
    end
  endtask

  task automatic test_addr_check();
    @(negedge clk);
    clear(); m_ready = 1'b1;
    pulse(32'hC78, 10'd5);
`ifdef BRAM_READER_ADDR_CHECK_EN
    total++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) $display("FAIL chk_reject: err %b done %b busy %b want 1 0 0", err, done, busy); else pass++;
    repeat (4) @(negedge clk);
    total++;
    if (rd_addrs.size() != 0 || done_cnt != 0 || err_cnt != 1) $display("FAIL chk_noread: reads %0d dones %0d errs %0d want 0 0 1", rd_addrs.size(), done_cnt, err_cnt); else pass++;
    clear();
    pulse(32'hC78, 10'd3);
    wait_done("chk_edge");
    total++;
    if (got.size() != 3 || err_cnt != 0) $display("FAIL chk_edge_count: words %0d errs %0d want 3 0", got.size(), err_cnt); else pass++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== bw(798 + i)) $display("FAIL chk_edge_data%0d: got %h want %h", i, got[i], bw(798 + i)); else pass++;
    end
`else
    total++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL nochk_accept: err %b busy %b want 0 1", err, busy); else pass++;
    wait_done("nochk");
    total++;
    if (got.size() != 5 || err_cnt != 0) $display("FAIL nochk_count: words %0d errs %0d want 5 0", got.size(), err_cnt); else pass++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got[i] !== bw(798 + i)) $display("FAIL nochk_data%0d: got %h want %h", i, got[i], bw(798 + i)); else pass++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_addr_check();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
